mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 7, giving the number of memory words.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the word width.
REQ-003 The block SHALL have parameter AW, default 3, giving the address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port clr_req, input, 1 bit: request a full memory clear.
REQ-007 The block SHALL have port clr_busy, output, 1 bit: high while the clear sequence runs.
REQ-008 The block SHALL have ports req0_valid (input, 1 bit), req0_addr (input, AW bits), req0_data (input, WIDTH bits) and req0_ready (output, 1 bit): requester 0 write channel.
REQ-009 The block SHALL have ports req1_valid, req1_addr, req1_data and req1_ready: requester 1 write channel, with the same directions and widths as requester 0.
REQ-010 The block SHALL have port rd_addr, input, AW bits: read address.
REQ-011 The block SHALL have port rd_data, output, WIDTH bits: registered read data.
REQ-012 The block SHALL have port err_addr, output, 1 bit: one-cycle pulse when an accepted write targets an address of DEPTH or above.

Function
REQ-013 The block SHALL hold a DEPTH x WIDTH memory with no reset on its contents.
REQ-014 The FSM SHALL have two states, CLR and RUN.
REQ-015 In CLR, the block SHALL write 0 to mem[ptr] each cycle, with ptr counting 0 to DEPTH-1.
REQ-016 After writing entry DEPTH-1, the FSM SHALL go to RUN on the next cycle, so that CLR lasts exactly DEPTH cycles.
REQ-017 clr_busy SHALL be 1 exactly while the state is CLR.
REQ-018 If clr_req is 1 in RUN, the FSM SHALL enter CLR on the next cycle with ptr = 0.
REQ-019 clr_req asserted during CLR SHALL be ignored; the sequence does not restart.
REQ-020 In CLR, req0_ready and req1_ready SHALL both be 0.
REQ-021 In RUN, at most one write SHALL be granted per cycle.
REQ-022 req0_ready and req1_ready SHALL be combinational from the valids and the arbiter state.
REQ-023 A write handshake SHALL complete when valid and ready are both 1 in the same cycle; the memory word updates at that clock edge.
REQ-024 When only one requester has valid = 1, that requester SHALL be granted.
REQ-025 When both requesters have valid = 1, the requester not granted most recently SHALL win (round-robin); last_grant resets to 1, so requester 0 wins first.
REQ-026 last_grant SHALL update only on a completed handshake.
REQ-027 A requester SHALL hold valid, addr and data stable until it is granted; the block does not check this.
REQ-028 A granted write with address of DEPTH or above SHALL complete the handshake, leave the memory unchanged and pulse err_addr for one cycle.
REQ-029 rd_data SHALL equal mem[rd_addr] registered, giving one cycle of latency.
REQ-030 On a same-cycle read and write to the same address, rd_data SHALL return the old value.
REQ-031 rd_data SHALL be 0 when the registered read is taken in CLR or when rd_addr is DEPTH or above.
REQ-032 ptr and all address comparisons SHALL be unsigned and AW bits wide, with no wrap beyond DEPTH-1.

Reset
REQ-033 While rst_n = 0, the block SHALL force state = CLR, ptr = 0, last_grant = 1, rd_data = 0 and err_addr = 0; clr_busy therefore reads 1 and both ready outputs read 0.
REQ-034 When rst_n is released, the clear sequence SHALL run automatically from ptr = 0.
REQ-035 A reset asserted mid-CLR or mid-RUN SHALL abort the current operation immediately; a write in flight that has not yet reached its clock edge is lost.

Structure
REQ-036 DEPTH, WIDTH, AW and the state type {CLR, RUN} SHALL live in the shared package mem_ctrl_pkg.
REQ-037 The two-requester round-robin arbiter SHALL be the sub-module rr_arb2, with inputs valid0/1, enable and accept, and outputs grant0/1.
REQ-038 Everything else SHALL stay in mem_access_ctrl.

Verification
REQ-039 Reset release scenario: clr_busy is 1 for 7 cycles then 0, and a subsequent read of each of addresses 0 to 6 returns 0x00.
REQ-040 Single-writer scenario: req0 writes 0xA5 to address 3 in RUN, then rd_addr = 3 gives rd_data = 0xA5 one cycle later, with req0_ready = 1 in the grant cycle.
REQ-041 Contention scenario: both requesters valid for 4 cycles (req0 writes 0x11 to address 1, req1 writes 0x22 to address 2) produces grants in the order 0, 1, 0, 1, and the memory ends with mem[1] = 0x11 and mem[2] = 0x22.
REQ-042 Bad-address scenario: req1 writes to address 7 completes the handshake, err_addr pulses for exactly 1 cycle and no memory word changes.
REQ-043 Mid-run clear scenario: clr_req after memory has been filled with 0xFF gives clr_busy = 1 for 7 cycles and ready = 0 during it; a second clr_req at cycle 3 of the clear does not extend it; all words read 0x00 afterwards.
REQ-044 Reset-during-clear scenario: rst_n pulsed low at CLR ptr = 4 restarts the clear at ptr = 0 and gives 7 full CLR cycles after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared parameters and FSM state type for mem_access_ctrl
//
// Purpose: default memory geometry (DEPTH words of WIDTH bits, AW address
// bits) and the two-state controller type used by mem_access_ctrl.
// Ports: none (package).
package mem_ctrl_pkg;

  localparam int DEPTH = 7;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin write arbiter
//
// Purpose: grants at most one of two requesters per cycle. With a single
// requester active it is granted; with both active, the one not granted
// most recently wins. The history only moves on a completed handshake.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   valid0/valid1  - request lines from requester 0/1
//   enable         - grants are only issued while enable is high
//   accept         - a granted request completed its handshake this cycle
//   grant0/grant1  - combinational grants (one-hot or zero)
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  input  logic accept,
  output logic grant0,
  output logic grant1
);

  // 1 = requester 1 was granted last; resets to 1 so requester 0 wins first.
  logic r_last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (accept) begin
      r_last_grant <= grant1;
    end
  end

  assign grant0 = enable & valid0 & (~valid1 |  r_last_grant);
  assign grant1 = enable & valid1 & (~valid0 | ~r_last_grant);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - two-writer memory controller with clear sequencer
//
// Purpose: DEPTH x WIDTH memory written by two round-robin arbitrated
// requesters and read through a registered port. A clear sequence zeroes
// every word after reset and on clr_req; writes are blocked meanwhile.
// Ports:
//   clk, rst_n                          - clock, asynchronous active-low reset
//   clr_req                             - request a full clear (ignored while clearing)
//   clr_busy                            - high while the clear sequence runs
//   req0_valid/addr/data, req0_ready    - requester 0 write channel
//   req1_valid/addr/data, req1_ready    - requester 1 write channel
//   rd_addr, rd_data                    - read address, registered read data
//   err_addr                            - one-cycle pulse on an accepted out-of-range write
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = mem_ctrl_pkg::DEPTH,
  parameter int WIDTH = mem_ctrl_pkg::WIDTH,
  parameter int AW    = mem_ctrl_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             err_addr
);

  // Comparing against the last valid index keeps every check AW bits wide
  // even when DEPTH == 2**AW.
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_err_addr;

  logic             w_run;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [AW-1:0]    w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_wr_in_range;

  assign w_run = (r_state == RUN);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .enable (w_run),
    .accept (w_accept),
    .grant0 (w_grant0),
    .grant1 (w_grant1)
  );

  // A grant is only raised for a valid requester, so any grant is a handshake.
  assign req0_ready    = w_grant0;
  assign req1_ready    = w_grant1;
  assign w_accept      = w_grant0 | w_grant1;
  assign w_wr_addr     = w_grant1 ? req1_addr : req0_addr;
  assign w_wr_data     = w_grant1 ? req1_data : req0_data;
  assign w_wr_in_range = (w_wr_addr <= LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      CLR: begin
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = RUN;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          w_state_nxt = CLR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Storage carries no reset; the clear sequence initialises it instead.
  always_ff @(posedge clk) begin
    if (r_state == CLR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_accept && w_wr_in_range) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Reading before the write lands at the same edge yields the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_err_addr <= 1'b0;
    end else begin
      r_rd_data  <= (w_run && (rd_addr <= LAST_ADDR)) ? r_mem[rd_addr] : '0;
      r_err_addr <= w_accept & ~w_wr_in_range;
    end
  end

  assign clr_busy = (r_state == CLR);
  assign rd_data  = r_rd_data;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int DEPTH = 7;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_req;
  logic             clr_busy;
  logic             req0_valid;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             err_addr;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: word contents, who was granted last, clear cycles left.
  logic [WIDTH-1:0] m_mem [0:7];
  bit               m_lg;
  int               m_clr_left;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .err_addr   (err_addr)
  );

  // Inputs change just after the falling edge, well away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [WIDTH-1:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (!clr_busy) break;
      n++;
      tick();
    end
  endtask

  task automatic do_write0(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, output bit ok);
    req0_addr  = a;
    req0_data  = d;
    req0_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req0_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req0_valid = 1'b0;
  endtask

  task automatic check_all_words(input string tag);
    logic [WIDTH-1:0] d;
    for (int a = 0; a < 8; a++) begin
      do_read(AW'(a), d);
      vectors++;
      if (d !== ((a < DEPTH) ? m_mem[a] : 8'h00)) begin
        miscompares++;
        $display("FAIL %s rd[%0d]: got %02h expected %02h", tag, a, d, (a < DEPTH) ? m_mem[a] : 8'h00);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; clr_req = 1'b0; rd_addr = '0;
    req0_valid = 1'b1; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b1; req1_addr = '0; req1_data = '0;
    repeat (3) tick();
    vectors += 5;
    if (clr_busy !== 1'b1)   begin miscompares++; $display("FAIL reset_busy: got %b expected 1", clr_busy); end
    if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
    if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready1: got %b expected 0", req1_ready); end
    if (rd_data !== 8'h00)   begin miscompares++; $display("FAIL reset_rd_data: got %02h expected 00", rd_data); end
    if (err_addr !== 1'b0)   begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_addr); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    count_busy(n);
    vectors++;
    if (n != DEPTH) begin miscompares++; $display("FAIL reset_clr_cycles: got %0d expected %0d", n, DEPTH); end
    model_clear_all();
    m_lg = 1'b1;
    m_clr_left = 0;
    check_all_words("reset");
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] d;
    bit win1;
    req0_addr = 3'd1; req0_data = 8'h11; req0_valid = 1'b1;
    req1_addr = 3'd2; req1_data = 8'h22; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      win1 = !m_lg;
      vectors += 2;
      if (req0_ready !== !win1) begin miscompares++; $display("FAIL contention_ready0 c%0d: got %b expected %b", k, req0_ready, !win1); end
      if (req1_ready !== win1)  begin miscompares++; $display("FAIL contention_ready1 c%0d: got %b expected %b", k, req1_ready, win1); end
      if (win1) m_mem[2] = 8'h22; else m_mem[1] = 8'h11;
      m_lg = win1;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    do_read(3'd1, d);
    vectors++;
    if (d !== 8'h11) begin miscompares++; $display("FAIL contention_mem1: got %02h expected 11", d); end
    do_read(3'd2, d);
    vectors++;
    if (d !== 8'h22) begin miscompares++; $display("FAIL contention_mem2: got %02h expected 22", d); end
  endtask

  task automatic test_single_writer();
    logic [WIDTH-1:0] d;
    req0_addr = 3'd3; req0_data = 8'hA5; req0_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready0: got %b expected 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    m_mem[3] = 8'hA5;
    m_lg = 1'b0;
    do_read(3'd3, d);
    vectors++;
    if (d !== 8'hA5) begin miscompares++; $display("FAIL single_rd: got %02h expected a5", d); end
  endtask

  task automatic test_bad_addr();
    req1_addr = 3'd7; req1_data = 8'h5A; req1_valid = 1'b1;
    #1;
    vectors++;
    if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL bad_ready1: got %b expected 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    m_lg = 1'b1;
    vectors++;
    if (err_addr !== 1'b1) begin miscompares++; $display("FAIL bad_err_pulse: got %b expected 1", err_addr); end
    tick();
    vectors++;
    if (err_addr !== 1'b0) begin miscompares++; $display("FAIL bad_err_len: got %b expected 0", err_addr); end
    check_all_words("bad_addr");
  endtask

  task automatic test_mid_clear();
    bit ok;
    int n;
    for (int a = 0; a < DEPTH; a++) begin
      do_write0(AW'(a), 8'hFF, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL fill_grant a%0d: got 0 expected 1", a); end
      else begin m_mem[a] = 8'hFF; m_lg = 1'b0; end
    end
    check_all_words("filled");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      clr_req = (n == 2);
      #1;
      if (!clr_busy) break;
      vectors += 2;
      if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL clear_ready0 c%0d: got %b expected 0", n, req0_ready); end
      if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL clear_ready1 c%0d: got %b expected 0", n, req1_ready); end
      n++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; clr_req = 1'b0;
    vectors++;
    if (n != DEPTH) begin miscompares++; $display("FAIL clear_cycles: got %0d expected %0d", n, DEPTH); end
    model_clear_all();
    check_all_words("cleared");
  endtask

  task automatic test_reset_during_clear();
    bit ok;
    int n;
    do_write0(3'd6, 8'h3C, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rdc_fill: got 0 expected 1"); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    vectors++;
    if (clr_busy !== 1'b1) begin miscompares++; $display("FAIL rdc_busy_ptr4: got %b expected 1", clr_busy); end
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    vectors += 2;
    if (clr_busy !== 1'b1)   begin miscompares++; $display("FAIL rdc_busy_in_reset: got %b expected 1", clr_busy); end
    if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL rdc_ready_in_reset: got %b expected 0", req0_ready); end
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b1;
    count_busy(n);
    vectors++;
    if (n != DEPTH) begin miscompares++; $display("FAIL rdc_clr_cycles: got %0d expected %0d", n, DEPTH); end
    m_lg = 1'b1;
    model_clear_all();
    check_all_words("rdc");
  endtask

  task automatic test_random();
    bit p0, p1, g0, g1, busy, e_err;
    logic [AW-1:0] a0, a1;
    logic [WIDTH-1:0] d0, d1, e_rd;
    p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    m_clr_left = 0;
    for (int c = 0; c < 200; c++) begin
      if (c < 170 && !p0 && ($urandom % 3 == 0)) begin p0 = 1'b1; a0 = AW'($urandom % 8); d0 = WIDTH'($urandom); end
      if (c < 170 && !p1 && ($urandom % 3 == 0)) begin p1 = 1'b1; a1 = AW'($urandom % 8); d1 = WIDTH'($urandom); end
      req0_valid = p0; req0_addr = a0; req0_data = d0;
      req1_valid = p1; req1_addr = a1; req1_data = d1;
      clr_req = (c < 170) && ($urandom % 50 == 0);
      rd_addr = AW'($urandom % 8);
      #1;
      busy = (m_clr_left > 0);
      g0 = !busy && p0 && (!p1 || m_lg);
      g1 = !busy && p1 && (!p0 || !m_lg);
      vectors += 3;
      if (clr_busy !== busy) begin miscompares++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, clr_busy, busy); end
      if (req0_ready !== g0) begin miscompares++; $display("FAIL rnd_ready0 c%0d: got %b expected %b", c, req0_ready, g0); end
      if (req1_ready !== g1) begin miscompares++; $display("FAIL rnd_ready1 c%0d: got %b expected %b", c, req1_ready, g1); end
      e_rd  = (busy || rd_addr >= DEPTH) ? 8'h00 : m_mem[rd_addr];
      e_err = (g0 && a0 >= DEPTH) || (g1 && a1 >= DEPTH);
      if (busy) begin
        m_mem[DEPTH - m_clr_left] = '0;
        m_clr_left--;
      end else begin
        if (g0) begin if (a0 < DEPTH) m_mem[a0] = d0; m_lg = 1'b0; p0 = 1'b0; end
        if (g1) begin if (a1 < DEPTH) m_mem[a1] = d1; m_lg = 1'b1; p1 = 1'b0; end
        if (clr_req) m_clr_left = DEPTH;
      end
      tick();
      vectors += 2;
      if (rd_data !== e_rd)   begin miscompares++; $display("FAIL rnd_rd c%0d: got %02h expected %02h", c, rd_data, e_rd); end
      if (err_addr !== e_err) begin miscompares++; $display("FAIL rnd_err c%0d: got %b expected %b", c, err_addr, e_err); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; clr_req = 1'b0;
    check_all_words("random_final");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_writer();
    test_bad_addr();
    test_mid_clear();
    test_reset_during_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
